aux_req_encoder: RTL
====================

# aux_req_encoder

Parametrised AUX request encoder for the AUX channel transmit path, successor to the fixed-size native message encoder. Accepts a request header plus, for writes, a buffered write payload. Emits the serialised request one byte at a time under a valid/ready handshake. Covers native and I2C-over-AUX commands, supports configurable payload depth, and resends a partially-acknowledged request with address and length adjusted by the acknowledged byte count.

## Interface
- MAX_DATA_BYTES, default 16: write payload buffer depth in bytes, range 1..256.
- CNT_W, default $clog2(MAX_DATA_BYTES+1): width of internal byte counters.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hdr_vld  in  1  request header valid.
- hdr_rdy  out  1  header accepted when hdr_vld & hdr_rdy.
- hdr_cmd  in  2  00 native write, 01 native read, 10 I2C write, 11 I2C read.
- hdr_mot  in  1  I2C middle-of-transaction bit; ignored for native.
- hdr_addr  in  20  native DPCD address, or I2C slave address in [6:0].
- hdr_len  in  8  payload bytes minus 1.
- wr_data  in  8  write payload byte.
- wr_vld  in  1  payload byte valid; accepted only in LOAD.
- retrans  in  1  single-cycle pulse requesting a resend.
- done_cnt  in  8  payload bytes already completed by the sink.
- out_byte  out  8  serialised request byte.
- out_vld  out  1  out_byte valid.
- out_rdy  in  1  downstream accepts out_byte.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on a rejected header or rejected retrans.

## Operation
- Command nibble:
  - native write = 1000; native read = 1001.
  - I2C write = {0,mot,0,0}; I2C read = {0,mot,0,1}.
- Request byte order: B0={cmd4,addr[19:16]}, B1=addr[15:8], B2=addr[7:0], B3=len, then write payload bytes 0..len.
- Read requests carry no payload.
- States and transitions:
  - IDLE: hdr_rdy=1.
    - Write with len+1 > MAX_DATA_BYTES: err pulse, stay in IDLE.
    - Other write: go to LOAD.
    - Read: go to SEND_HDR.
  - LOAD: store len+1 wr_vld bytes at increasing buffer index. After the last byte, go to SEND_HDR.
  - SEND_HDR: emit B0..B3. Then SEND_DATA if write, else HOLD.
  - SEND_DATA: emit payload from the start index up to index len. Then HOLD.
  - HOLD: request and buffer retained; hdr_rdy=1.
    - New header: handled exactly as in IDLE.
    - retrans with done_cnt=k, where k ≤ len: latch offset k, go to SEND_HDR.
    - retrans with k > len: err pulse, stay in HOLD.
- Resend after retrans with offset k:
  - Native: B0..B2 use (addr+k) mod 2^20.
  - I2C: address is unchanged.
  - B3 = len−k.
  - Payload starts at buffer index k.
  - k=0 resends the identical request.
- Offset is cleared when a new header is accepted.
- retrans outside HOLD is ignored; no err pulse.
- retrans and hdr_vld in the same HOLD cycle: retrans wins and hdr_rdy is 0 that cycle.
- Arithmetic: addr+k is 20-bit wrap. len−k is 8-bit and never underflows, because k ≤ len is enforced.

## Timing
- All outputs are registered.
- Reset values: out_byte=0, out_vld=0, hdr_rdy=1, busy=0, err=0, state=IDLE, offset=0, buffer contents don't-care.
- Header accepted at cycle T:
  - Read: out_vld=1 with B0 at T+1.
  - Write: the first wr_vld byte can be taken at T+1. B0 appears the cycle after the last payload byte is stored.
- Handshake:
  - A byte transfers on out_vld & out_rdy.
  - While out_vld & !out_rdy, out_byte and out_vld hold stable.
  - With out_rdy held high, one byte per cycle with no bubbles between header and payload.
- After the final byte transfers, out_vld falls in the next cycle and the block enters HOLD.
- retrans at cycle R in HOLD: B0 of the resend at R+1.
- rst asserted at any point, including mid-LOAD or mid-send: immediate return to reset values. A partially sent request is abandoned.

## Structure
- Package aux_enc_pkg holds:
  - cmd encoding constants: NATIVE_WR, NATIVE_RD, I2C_WR, I2C_RD, and the nibble base values;
  - the state enum: IDLE, LOAD, SEND_HDR, SEND_DATA, HOLD;
  - header byte count, fixed at 4.
- One sub-module, aux_enc_buf: MAX_DATA_BYTES×8 register file with a write pointer and an indexed registered read port.
- FSM, header mux and offset arithmetic live in aux_req_encoder.

## Test plan
- Native read, addr=0x00100, len=0x0F, out_rdy=1 -> bytes 0x90,0x01,0x00,0x0F, with B0 at T+1; HOLD afterwards.
- Native write, addr=0x00200, len=3, data A1,A2,A3,A4 -> bytes 0x80,0x02,0x00,0x03,A1,A2,A3,A4; out_vld low afterwards.
- Same write, then retrans with done_cnt=2 -> bytes 0x80,0x02,0x02,0x01,A3,A4.
- I2C write, mot=1, addr=0x50, len=0, data 0x3C, with out_rdy toggled 1,0,0,1,... -> bytes 0x40,0x00,0x50,0x00,0x3C; each byte held stable while stalled.
- Write with len=16 when MAX_DATA_BYTES=16 -> err pulse, no output. retrans in HOLD with done_cnt=5 after len=3 -> err pulse, no output.
- rst asserted after B1 of a write -> out_vld=0 and hdr_rdy=1 immediately. A following read request is sent cleanly from B0.

Source files
------------

// File: rtl/aux_req_encoder_pkg.sv
// Shared types and constants for the AUX request encoder.
// Command codes, FSM states and the header byte builder.
package aux_enc_pkg;

    typedef enum logic [1:0] {
        NATIVE_WR = 2'b00,
        NATIVE_RD = 2'b01,
        I2C_WR    = 2'b10,
        I2C_RD    = 2'b11
    } cmd_t;

    localparam logic [3:0] NATIVE_NIB = 4'b1000;
    localparam logic [3:0] I2C_NIB    = 4'b0000;
    localparam int         HDR_BYTES  = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_HDR,
        SEND_DATA,
        HOLD
    } state_t;

    // Header byte sel (0..3) of a request resent from offset off.
    // Native addresses advance by off; I2C slave addresses do not.
    function automatic logic [7:0] hdr_byte(
        input cmd_t        cmd,
        input logic        mot,
        input logic [19:0] addr,
        input logic [7:0]  len,
        input logic [7:0]  off,
        input logic [1:0]  sel
    );
        logic [19:0] a;
        logic [3:0]  nib;
        logic [7:0]  b;
        a      = cmd[1] ? addr : addr + 20'(off);
        nib    = cmd[1] ? (I2C_NIB | {1'b0, mot, 2'b00}) : NATIVE_NIB;
        nib[0] = cmd[0];
        unique case (sel)
            2'd0:    b = {nib, a[19:16]};
            2'd1:    b = a[15:8];
            2'd2:    b = a[7:0];
            default: b = len - off;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/aux_req_encoder_if.sv
// Request-side and byte-stream handshake bundle of the encoder.
// master drives requests, slave is the encoder.
interface aux_req_encoder_if;
    import aux_enc_pkg::*;

    logic        hdr_vld;
    logic        hdr_rdy;
    cmd_t        hdr_cmd;
    logic        hdr_mot;
    logic [19:0] hdr_addr;
    logic [7:0]  hdr_len;
    logic [7:0]  wr_data;
    logic        wr_vld;
    logic        retrans;
    logic [7:0]  done_cnt;
    logic [7:0]  out_byte;
    logic        out_vld;
    logic        out_rdy;
    logic        busy;
    logic        err;

    modport master (
        output hdr_vld, hdr_cmd, hdr_mot, hdr_addr, hdr_len,
        output wr_data, wr_vld, retrans, done_cnt, out_rdy,
        input  hdr_rdy, out_byte, out_vld, busy, err
    );

    modport slave (
        input  hdr_vld, hdr_cmd, hdr_mot, hdr_addr, hdr_len,
        input  wr_data, wr_vld, retrans, done_cnt, out_rdy,
        output hdr_rdy, out_byte, out_vld, busy, err
    );

endinterface

// File: rtl/aux_enc_buf.sv
// Write payload buffer: sequential write pointer and an
// indexed read port with a registered output.
module aux_enc_buf #(
    parameter int MAX_DATA_BYTES = 16,
    parameter int CNT_W          = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_clr_i,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_data_i,
    output logic [CNT_W-1:0] wr_ptr_o,
    input  logic             rd_en_i,
    input  logic [CNT_W-1:0] rd_idx_i,
    output logic [7:0]       rd_data_o
);
    localparam int AW    = (MAX_DATA_BYTES > 1) ? $clog2(MAX_DATA_BYTES) : 1;
    localparam int DEPTH = 2 ** AW;

    logic [7:0]       mem_q [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q;
    logic [7:0]       rd_q;

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_i && !wr_clr_i && int'(wr_ptr_q) < MAX_DATA_BYTES) begin
            mem_q[AW'(wr_ptr_q)] <= wr_data_i;
        end
    end

    // Write pointer and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_q     <= '0;
        end else begin
            if (wr_clr_i) begin
                wr_ptr_q <= '0;
            end else if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en_i) begin
                rd_q <= (int'(rd_idx_i) < MAX_DATA_BYTES) ?
                        mem_q[AW'(rd_idx_i)] : 8'h00;
            end
        end
    end

    assign wr_ptr_o  = wr_ptr_q;
    assign rd_data_o = rd_q;

endmodule

// File: rtl/aux_req_encoder.sv
// AUX request encoder: serialises header and write payload,
// and resends from an acknowledged offset on retrans.
module aux_req_encoder
    import aux_enc_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 16,
    parameter int CNT_W          = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    aux_req_encoder_if.slave bus
);
    state_t           state_q;
    cmd_t             cmd_q;
    logic             mot_q;
    logic [19:0]      addr_q;
    logic [7:0]       len_q;
    logic [7:0]       off_q;
    logic [1:0]       hidx_q;
    logic [CNT_W-1:0] didx_q;
    logic [7:0]       out_byte_q;
    logic             out_vld_q;
    logic             hdr_rdy_q;
    logic             busy_q;
    logic             err_q;

    logic             xfer;
    logic             rt;
    logic             hdr_rdy;
    logic             hdr_take;
    logic             too_big;
    logic             hdr_last;
    logic             load_last;
    logic             wr_clr;
    logic             wr_en;
    logic [CNT_W-1:0] wr_ptr;
    logic             rd_en;
    logic [CNT_W-1:0] rd_idx;
    logic [7:0]       rd_data;

    assign xfer      = out_vld_q & bus.out_rdy;
    assign rt        = bus.retrans & (state_q == HOLD);
    assign hdr_rdy   = hdr_rdy_q & ~rt;
    assign hdr_take  = bus.hdr_vld & hdr_rdy;
    assign too_big   = ~bus.hdr_cmd[0] &
                       (int'(bus.hdr_len) + 1 > MAX_DATA_BYTES);
    assign hdr_last  = xfer & (hidx_q == 2'(HDR_BYTES - 1));
    assign load_last = bus.wr_vld & (int'(wr_ptr) == int'(len_q));
    assign wr_clr    = (state_q != LOAD);
    assign wr_en     = (state_q == LOAD) & bus.wr_vld;

    // Read-ahead: keep the next payload byte ready so data follows
    // the header with no bubble.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = '0;
        if (state_q == SEND_HDR) begin
            rd_en  = 1'b1;
            rd_idx = CNT_W'(off_q) + (hdr_last ? 1'b1 : 1'b0);
        end else if (state_q == SEND_DATA && xfer) begin
            rd_en  = 1'b1;
            rd_idx = didx_q + CNT_W'(2);
        end
    end

    aux_enc_buf #(
        .MAX_DATA_BYTES(MAX_DATA_BYTES),
        .CNT_W         (CNT_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_clr_i (wr_clr),
        .wr_en_i  (wr_en),
        .wr_data_i(bus.wr_data),
        .wr_ptr_o (wr_ptr),
        .rd_en_i  (rd_en),
        .rd_idx_i (rd_idx),
        .rd_data_o(rd_data)
    );

    // Request FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= NATIVE_WR;
            mot_q      <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            off_q      <= '0;
            hidx_q     <= '0;
            didx_q     <= '0;
            out_byte_q <= '0;
            out_vld_q  <= 1'b0;
            hdr_rdy_q  <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE, HOLD: begin
                    if (rt) begin
                        if (bus.done_cnt <= len_q) begin
                            off_q      <= bus.done_cnt;
                            out_byte_q <= hdr_byte(cmd_q, mot_q, addr_q,
                                              len_q, bus.done_cnt, 2'd0);
                            out_vld_q  <= 1'b1;
                            hidx_q     <= '0;
                            hdr_rdy_q  <= 1'b0;
                            state_q    <= SEND_HDR;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (hdr_take) begin
                        if (too_big) begin
                            err_q <= 1'b1;
                        end else begin
                            cmd_q     <= bus.hdr_cmd;
                            mot_q     <= bus.hdr_mot;
                            addr_q    <= bus.hdr_addr;
                            len_q     <= bus.hdr_len;
                            off_q     <= '0;
                            busy_q    <= 1'b1;
                            hdr_rdy_q <= 1'b0;
                            if (bus.hdr_cmd[0]) begin
                                out_byte_q <= hdr_byte(bus.hdr_cmd,
                                    bus.hdr_mot, bus.hdr_addr,
                                    bus.hdr_len, 8'd0, 2'd0);
                                out_vld_q  <= 1'b1;
                                hidx_q     <= '0;
                                state_q    <= SEND_HDR;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (load_last) begin
                        out_byte_q <= hdr_byte(cmd_q, mot_q, addr_q,
                                               len_q, off_q, 2'd0);
                        out_vld_q  <= 1'b1;
                        hidx_q     <= '0;
                        state_q    <= SEND_HDR;
                    end
                end
                SEND_HDR: begin
                    if (xfer) begin
                        if (!hdr_last) begin
                            hidx_q     <= hidx_q + 2'd1;
                            out_byte_q <= hdr_byte(cmd_q, mot_q, addr_q,
                                              len_q, off_q, hidx_q + 2'd1);
                        end else if (!cmd_q[0]) begin
                            out_byte_q <= rd_data;
                            didx_q     <= CNT_W'(off_q);
                            state_q    <= SEND_DATA;
                        end else begin
                            out_vld_q <= 1'b0;
                            hdr_rdy_q <= 1'b1;
                            state_q   <= HOLD;
                        end
                    end
                end
                SEND_DATA: begin
                    if (xfer) begin
                        if (int'(didx_q) == int'(len_q)) begin
                            out_vld_q <= 1'b0;
                            hdr_rdy_q <= 1'b1;
                            state_q   <= HOLD;
                        end else begin
                            out_byte_q <= rd_data;
                            didx_q     <= didx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_vld_q <= 1'b0;
                    hdr_rdy_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_byte = out_byte_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.hdr_rdy  = hdr_rdy;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule
